// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: per-register pending-write scoreboard driving
// IF/ID stall and flush controls, plus a free-running stall-cycle counter.
module id_hazard_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_BITS  = 2,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 idValid,
  input  logic [3:0]           idSrc1No,
  input  logic [3:0]           idSrc2No,
  input  logic                 idUseSrc1,
  input  logic                 idUseSrc2,
  input  logic                 idWrReg,
  input  logic [3:0]           idDstNo,
  input  logic                 wbWrReg,
  input  logic [3:0]           wbRegNo,
  input  logic                 exRedirect,
  output logic                 stallIF,
  output logic                 flushIF,
  output logic                 flushID,
  output logic                 stallID,
  output logic                 pendingAny,
  output logic [PERF_BITS-1:0] stallCycles
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cntVal [NUM_REGS];
  logic [NUM_REGS-1:0] cntNonZero;
  logic                src1Busy;
  logic                src2Busy;
  logic                dstFull;
  logic                haz;
  logic                issue;
  logic [PERF_BITS-1:0] stallCyclesReg;

  assign src1Busy = idUseSrc1 && cntNonZero[idSrc1No];
  assign src2Busy = idUseSrc2 && cntNonZero[idSrc2No];
  assign dstFull  = idWrReg && (cntVal[idDstNo] == CNT_MAX);
  assign haz      = idValid && (src1Busy || src2Busy || dstFull);
  assign issue    = idValid && idWrReg && !haz && !exRedirect;

  // Redirect outranks the hazard: the stalled instruction is on the wrong path anyway.
  always_comb begin
    stallIF = 1'b0;
    flushIF = 1'b0;
    flushID = 1'b0;
    if (reset) begin
      flushIF = 1'b1;
      flushID = 1'b1;
    end else if (exRedirect) begin
      flushIF = 1'b1;
      flushID = 1'b1;
    end else if (haz) begin
      stallIF = 1'b1;
      flushID = 1'b1;
    end
  end

  assign stallID = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gSlot
      logic [CNT_BITS-1:0] cntReg;
      logic                incHit;
      logic                decHit;

      assign incHit = issue && (idDstNo == 4'(gi));
      assign decHit = wbWrReg && (wbRegNo == 4'(gi));

      // Issue and retire to the same register cancel; a retire of an empty slot is ignored.
      always_ff @(posedge clk) begin
        if (reset) begin
          cntReg <= '0;
        end else if (incHit && !decHit) begin
          cntReg <= cntReg + 1'b1;
        end else if (decHit && !incHit && (cntReg != '0)) begin
          cntReg <= cntReg - 1'b1;
        end
      end

      assign cntVal[gi]     = cntReg;
      assign cntNonZero[gi] = (cntReg != '0);
    end
  endgenerate

  assign pendingAny = |cntNonZero;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCyclesReg <= '0;
    end else if (stallIF) begin
      stallCyclesReg <= stallCyclesReg + 1'b1;
    end
  end

  assign stallCycles = stallCyclesReg;

  // Writeback of a register with nothing outstanding means the pipeline lost track.
  always_ff @(posedge clk) begin
    if (!reset && wbWrReg && !(issue && (idDstNo == wbRegNo))) begin
      assert (cntVal[wbRegNo] != '0);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed scenarios followed by legal random
// traffic, each cycle checked against a count-per-register reference model.
module tb_id_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        idValid;
  logic [3:0]  idSrc1No;
  logic [3:0]  idSrc2No;
  logic        idUseSrc1;
  logic        idUseSrc2;
  logic        idWrReg;
  logic [3:0]  idDstNo;
  logic        wbWrReg;
  logic [3:0]  wbRegNo;
  logic        exRedirect;
  logic        stallIF;
  logic        flushIF;
  logic        flushID;
  logic        stallID;
  logic        pendingAny;
  logic [31:0] stallCycles;

  id_hazard_ctrl #(.NUM_REGS(16), .CNT_BITS(2), .PERF_BITS(32)) dut (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idSrc1No(idSrc1No), .idSrc2No(idSrc2No),
    .idUseSrc1(idUseSrc1), .idUseSrc2(idUseSrc2),
    .idWrReg(idWrReg), .idDstNo(idDstNo),
    .wbWrReg(wbWrReg), .wbRegNo(wbRegNo), .exRedirect(exRedirect),
    .stallIF(stallIF), .flushIF(flushIF), .flushID(flushID), .stallID(stallID),
    .pendingAny(pendingAny), .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          stateKnown;
    logic        stallIF;
    logic        flushIF;
    logic        flushID;
    logic        pendingAny;
    logic [31:0] stallCycles;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          mcnt[16];
  logic [31:0] msc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: outstanding writes per register, plus the stall counter.
  task automatic step();
    exp_t e;
    bit   haz;
    bit   any;
    any = 0;
    foreach (mcnt[i]) if (mcnt[i] > 0) any = 1;
    haz = idValid && ((idUseSrc1 && mcnt[idSrc1No] > 0) ||
                      (idUseSrc2 && mcnt[idSrc2No] > 0) ||
                      (idWrReg && mcnt[idDstNo] >= 3));
    e.stateKnown  = 1;
    e.pendingAny  = any;
    e.stallCycles = msc;
    if (reset)           begin e.stallIF = 0; e.flushIF = 1; e.flushID = 1; end
    else if (exRedirect) begin e.stallIF = 0; e.flushIF = 1; e.flushID = 1; end
    else if (haz)        begin e.stallIF = 1; e.flushIF = 0; e.flushID = 1; end
    else                 begin e.stallIF = 0; e.flushIF = 0; e.flushID = 0; end
    expQ.push_back(e);
    if (reset) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      msc = 0;
    end else begin
      if (idValid && idWrReg && !haz && !exRedirect) mcnt[idDstNo]++;
      if (wbWrReg) mcnt[wbRegNo]--;
      if (e.stallIF) msc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; idValid = 0; idSrc1No = 0; idSrc2No = 0; idUseSrc1 = 0; idUseSrc2 = 0;
    idWrReg = 0; idDstNo = 0; wbWrReg = 0; wbRegNo = 0; exRedirect = 0;
  endtask

  task automatic randomId();
    idValid   = ($urandom_range(0, 4) != 0);
    idSrc1No  = 4'($urandom_range(0, 15));
    idSrc2No  = 4'($urandom_range(0, 15));
    idUseSrc1 = 1'($urandom_range(0, 1));
    idUseSrc2 = 1'($urandom_range(0, 1));
    idWrReg   = ($urandom_range(0, 4) < 3);
    idDstNo   = 4'($urandom_range(0, 15));
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("stallIF", 32'(stallIF), 32'(e.stallIF));
        check("flushIF", 32'(flushIF), 32'(e.flushIF));
        check("flushID", 32'(flushID), 32'(e.flushID));
        check("stallID", 32'(stallID), 32'd0);
        if (e.stateKnown) begin
          check("pendingAny", 32'(pendingAny), 32'(e.pendingAny));
          check("stallCycles", stallCycles, e.stallCycles);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] sc0;
    int          busy[$];
    idle();
    foreach (mcnt[i]) mcnt[i] = 0;
    msc = 0;
    @(posedge clk);
    #1;

    // Reset cycle with arbitrary decode inputs; pre-reset state is unknown.
    randomId();
    reset = 1; exRedirect = 1'($urandom_range(0, 1));
    expQ.push_back('{stateKnown: 0, stallIF: 0, flushIF: 1, flushID: 1, pendingAny: 0, stallCycles: 0});
    foreach (mcnt[i]) mcnt[i] = 0;
    msc = 0;
    @(posedge clk);
    #1;
    idle();
    check("post_reset_pendingAny", 32'(pendingAny), 32'd0);
    check("post_reset_stallCycles", stallCycles, 32'd0);
    step();
    $display("scenario reset done");

    // Back-to-back RAW on r3: three bubbles, release after writeback.
    sc0 = stallCycles;
    idle(); idValid = 1; idWrReg = 1; idDstNo = 3; step();
    idle(); idValid = 1; idUseSrc1 = 1; idSrc1No = 3; step(); step();
    wbWrReg = 1; wbRegNo = 3; step();
    wbWrReg = 0; step();
    check("raw_stall_len", stallCycles - sc0, 32'd3);
    $display("scenario raw done");

    // Redirect while a RAW on r5 is pending.
    idle(); idValid = 1; idWrReg = 1; idDstNo = 5; step();
    sc0 = stallCycles;
    idle(); idValid = 1; idUseSrc1 = 1; idSrc1No = 5; idWrReg = 1; idDstNo = 5; exRedirect = 1; step();
    check("redirect_no_count", stallCycles - sc0, 32'd0);
    idle(); wbWrReg = 1; wbRegNo = 5; step();
    idle(); step();
    check("redirect_no_issue", 32'(pendingAny), 32'd0);
    $display("scenario redirect done");

    // Issue and retire of r2 in the same cycle.
    idle(); idValid = 1; idWrReg = 1; idDstNo = 2; step();
    idle(); idValid = 1; idWrReg = 1; idDstNo = 2; wbWrReg = 1; wbRegNo = 2; step();
    idle(); step();
    idle(); wbWrReg = 1; wbRegNo = 2; step();
    idle(); step();
    $display("scenario same-reg issue/retire done");

    // Saturation of r7.
    for (int k = 0; k < 3; k++) begin idle(); idValid = 1; idWrReg = 1; idDstNo = 7; step(); end
    idle(); idValid = 1; idWrReg = 1; idDstNo = 7; idUseSrc1 = 1; idSrc1No = 1; step(); step();
    wbWrReg = 1; wbRegNo = 7; step();
    wbWrReg = 0; step();
    for (int k = 0; k < 3; k++) begin idle(); wbWrReg = 1; wbRegNo = 7; step(); end
    idle(); step();
    $display("scenario saturation done");

    // Unused source pointing at a busy register.
    for (int k = 0; k < 2; k++) begin idle(); idValid = 1; idWrReg = 1; idDstNo = 4; step(); end
    sc0 = stallCycles;
    idle(); idValid = 1; idSrc2No = 4; idUseSrc2 = 0; idWrReg = 1; idDstNo = 9; step();
    check("unused_src_no_stall", stallCycles - sc0, 32'd0);
    idle(); wbWrReg = 1; wbRegNo = 4; step();
    wbRegNo = 9; step();
    wbRegNo = 4; step();
    idle(); step();
    $display("scenario unused source done");

    // Random legal traffic: retire only registers with outstanding writes.
    for (int n = 0; n < 3000; n++) begin
      idle();
      randomId();
      exRedirect = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      busy.delete();
      foreach (mcnt[i]) if (mcnt[i] > 0) busy.push_back(i);
      if (busy.size() > 0 && $urandom_range(0, 9) < 4) begin
        wbWrReg = 1;
        wbRegNo = 4'(busy[$urandom_range(0, busy.size() - 1)]);
      end
      step();
      if (n % 500 == 499) $display("random cycles %0d done, stallCycles=%0d", n + 1, stallCycles);
    end

    idle();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Decode-stage hazard controller that generates the `stall` and `flush` controls consumed by the IF and ID pipeline latches. It keeps a per-register scoreboard of in-flight register writes, issued when an instruction leaves decode and retired at writeback. It holds decode while a source register is pending and injects a bubble into the ID latch. On an EX-stage branch redirect it flushes both front-end latches. It also keeps a free-running stall-cycle performance counter.

## Interface
- `NUM_REGS`, 16: architectural registers; register numbers are 4 bits.
- `CNT_BITS`, 2: per-register pending-write counter width; maximum count is 3.
- `PERF_BITS`, 32: stall-cycle counter width.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `idValid` in 1: decode holds a real instruction.
- `idSrc1No`, `idSrc2No` in 4 each: source register numbers.
- `idUseSrc1`, `idUseSrc2` in 1 each: the source is actually read.
- `idWrReg` in 1: the decoded instruction writes a register.
- `idDstNo` in 4: destination register number.
- `wbWrReg` in 1: writeback commits a register write this cycle.
- `wbRegNo` in 4: register being written back.
- `exRedirect` in 1: branch/jump taken in EX; PC is redirected.
- `stallIF` out 1: hold PC and the IF latch.
- `flushIF` out 1: clear the IF latch.
- `flushID` out 1: load a bubble into the ID latch. A bubble has all-zero fields, so `wrReg`=0 and `wrMem`=0.
- `stallID` out 1: tied 0. The ID latch never holds; it takes a bubble instead.
- `pendingAny` out 1: some scoreboard counter is nonzero.
- `stallCycles` out `PERF_BITS`: number of cycles with `stallIF`=1 and `exRedirect`=0.

## Operation
- Scoreboard:
  - `NUM_REGS` counters of `CNT_BITS` each, written `cnt[r]`.
  - `cnt[r]` is the number of issued, not-yet-written-back writes to `r`.
- Hazard condition `haz`, evaluated from the current `cnt` and the ID inputs:
  - `idValid` and (`idUseSrc1` and `cnt[idSrc1No]`≠0, or `idUseSrc2` and `cnt[idSrc2No]`≠0), or
  - `idValid` and `idWrReg` and `cnt[idDstNo]`==3 (counter would saturate).
- Outputs, in priority order:
  - `reset`: forces `stallIF`=0, `flushIF`=1, `flushID`=1 combinationally.
  - `exRedirect`=1: `flushIF`=1, `flushID`=1, `stallIF`=0. The redirect overrides `haz`.
  - else `haz`=1: `stallIF`=1, `flushID`=1, `flushIF`=0.
  - else: all three outputs 0.
- Issue:
  - `issue` = `idValid` and `idWrReg` and not `haz` and not `exRedirect`.
  - On `issue`, `cnt[idDstNo]` increments.
- Retire:
  - `wbWrReg` decrements `cnt[wbRegNo]`.
  - A decrement of a zero counter is a protocol error. The counter stays 0 and a simulation-only assertion fires.
- Simultaneous issue and retire to the same register: the count is unchanged.
- Simultaneous issue and retire to different registers: both counters update.
- No forwarding exists. Writeback data is not visible to decode in the same cycle, so a hazard on a register being written back this cycle still stalls that cycle and releases the next.
- `exRedirect` does not touch the scoreboard. Instructions already past the ID latch still reach writeback and retire normally.
- `stallCycles`:
  - Increments when `stallIF`=1.
  - Wraps modulo 2^`PERF_BITS`.
- `pendingAny` is the OR of all counters being nonzero. It is registered-state-derived: no dependence on same-cycle inputs.

## Timing
- Reset (synchronous): at the posedge with `reset`=1, all `cnt`←0 and `stallCycles`←0.
  - After that edge: `pendingAny`=0 and `stallCycles`=0.
  - While `reset` is high: `flushIF`=`flushID`=1 and `stallIF`=0.
- Reset mid-operation discards all pending counts. The latches are reset in the same cycle, so this is consistent.
- `stallIF`, `flushIF`, `flushID` are combinational from current state plus inputs, with zero latency. They are sampled by the latches at the same edge.
- Counter updates take effect at the next posedge. A consumer of a single-cycle producer therefore sees `haz`=1 starting the cycle after the producer issues.
- RAW stall length:
  - Release comes the cycle after the producer's `wbWrReg` pulse.
  - With the EX→MEM→WB pipeline this gives 3 bubble cycles for back-to-back dependent instructions.

## Test plan
- Reset → `reset`=1 for 1 cycle with arbitrary inputs → the next cycle shows `pendingAny`=0, `stallCycles`=0, and all counters 0. During the reset cycle, `flushIF`=`flushID`=1.
- Back-to-back RAW:
  - Stimulus: issue writer r3 (`idValid`=1, `idWrReg`=1, `idDstNo`=3), then a reader of r3 (`idUseSrc1`=1, `idSrc1No`=3). Pulse `wbWrReg`/`wbRegNo`=3 three cycles later.
  - Required: `stallIF`=`flushID`=1 for exactly 3 cycles, release on the 4th, and `stallCycles`=3.
- Redirect over hazard:
  - Stimulus: `exRedirect`=1 in the same cycle as a pending RAW on r5.
  - Required: `flushIF`=`flushID`=1, `stallIF`=0, no issue, `cnt[5]` unchanged, and `stallCycles` not incremented.
- Issue and retire on the same register:
  - Stimulus: `cnt[2]`=1; issue a write to r2 while `wbWrReg`=1, `wbRegNo`=2.
  - Required: `cnt[2]` stays 1 and `pendingAny`=1.
- Saturation:
  - Stimulus: three writes to r7 with no retire, then a fourth write to r7 that does not read r7.
  - Required: the fourth stalls until one `wbWrReg`/`wbRegNo`=7 pulse, then issues; `cnt[7]` returns to 3.
- Unused source: `cnt[4]`=2 and a decode with `idSrc2No`=4, `idUseSrc2`=0 → no stall, and the instruction issues.
